// File: rtl/hazard_ctrl_sb.sv
// Stall/flush controller: multi-cycle load-use bubbles, a long-latency scoreboard
// with an outstanding-op limit, and a watchdog on sustained front-end stalls.
module hazard_ctrl_sb #(
    parameter int REG_ADDR_W      = 5,
    parameter int NUM_REGS        = 32,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int LU_DEPTH        = 2,
    parameter int WATCHDOG_LIMIT  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ID_rs1,
    input  logic [REG_ADDR_W-1:0] ID_rs2,
    input  logic [REG_ADDR_W-1:0] ID_rd,
    input  logic                  ID_rs1_valid,
    input  logic                  ID_rs2_valid,
    input  logic                  ID_rd_valid,
    input  logic                  EX_valid,
    input  logic                  EX_is_load,
    input  logic [REG_ADDR_W-1:0] EX_rd,
    input  logic                  lu_issue,
    input  logic [REG_ADDR_W-1:0] lu_issue_rd,
    input  logic                  lu_done,
    input  logic [REG_ADDR_W-1:0] lu_done_rd,
    input  logic                  branch_prediction_miss,
    input  logic                  EX_jump,
    input  logic                  trap_done,
    input  logic                  csr_ready,
    input  logic                  standby_mode,
    input  logic                  pth_done_flush,
    output logic                  IF_ID_stall,
    output logic                  ID_EX_stall,
    output logic                  EX_MEM_stall,
    output logic                  MEM_WB_stall,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_flush,
    output logic                  EX_MEM_flush,
    output logic                  MEM_WB_flush,
    output logic [NUM_REGS-1:0]   sb_busy,
    output logic                  lu_full,
    output logic                  stall_timeout,
    output logic                  sb_error
);

    localparam int OUT_W = (LU_DEPTH > 1) ? $clog2(LU_DEPTH + 1) : 1;
    localparam int WD_W  = (WATCHDOG_LIMIT > 1) ? $clog2(WATCHDOG_LIMIT + 1) : 1;
    localparam logic [OUT_W-1:0] LU_MAX  = OUT_W'(LU_DEPTH);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(WATCHDOG_LIMIT);
    localparam logic [2:0]       LU_INIT = 3'(LOAD_USE_CYCLES - 1);
    localparam logic             WD_EN   = (WATCHDOG_LIMIT != 0);

    typedef enum logic [1:0] {IDLE, LOAD_STALL, SB_STALL} state_e;

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [OUT_W-1:0]     out_q, out_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 timeout_q, timeout_d;
    logic                 err_q, err_d;

    logic rs1_hit, rs2_hit, rd_hit, load_hit, sb_hit, full_hit, done_ok, stall_req;

    assign rs1_hit  = ID_rs1_valid && (ID_rs1 != '0);
    assign rs2_hit  = ID_rs2_valid && (ID_rs2 != '0);
    assign rd_hit   = ID_rd_valid && (ID_rd != '0);
    assign load_hit = EX_valid && EX_is_load && (EX_rd != '0) &&
                      ((rs1_hit && (ID_rs1 == EX_rd)) || (rs2_hit && (ID_rs2 == EX_rd)));
    assign sb_hit   = (rs1_hit && busy_q[ID_rs1]) || (rs2_hit && busy_q[ID_rs2]) ||
                      (rd_hit && busy_q[ID_rd]);
    assign lu_full  = (out_q == LU_MAX);
    assign full_hit = lu_full && lu_issue;

    assign sb_busy       = busy_q;
    assign stall_timeout = timeout_q;
    assign sb_error      = err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_req    = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        MEM_WB_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        if (!reset) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (pth_done_flush) begin
            {IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush} = 4'hF;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!trap_done || !csr_ready) begin
            {IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall} = 4'hF;
        end else if (standby_mode) begin
            IF_ID_stall = 1'b1;
            ID_EX_stall = 1'b1;
        end else if (branch_prediction_miss || EX_jump) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_hit) begin
                        stall_req = 1'b1;
                        if (LU_INIT != 3'd0) begin
                            state_d = LOAD_STALL;
                            cnt_d   = LU_INIT;
                        end
                    end else if (sb_hit) begin
                        stall_req = 1'b1;
                        state_d   = SB_STALL;
                    end
                end
                LOAD_STALL: begin
                    stall_req = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                SB_STALL: begin
                    stall_req = 1'b1;
                    if (!sb_hit) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // A full long-latency unit freezes the whole front end, so any bubble waits.
            if (full_hit) begin
                IF_ID_stall  = 1'b1;
                ID_EX_stall  = 1'b1;
                EX_MEM_stall = 1'b1;
                state_d      = state_q;
                cnt_d        = cnt_q;
            end else if (stall_req) begin
                IF_ID_stall = 1'b1;
                ID_EX_flush = 1'b1;
            end
        end
    end

    // Clearing before setting keeps a same-register issue/done pair marked busy.
    always_comb begin
        done_ok = lu_done && (out_q != '0) && ((lu_done_rd == '0) || busy_q[lu_done_rd]);
        busy_d  = busy_q;
        out_d   = out_q;
        err_d   = err_q || (lu_done && !done_ok);
        if (done_ok) busy_d[lu_done_rd] = 1'b0;
        if (lu_issue && (lu_issue_rd != '0)) busy_d[lu_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
        case ({lu_issue, done_ok})
            2'b10:   if (out_q != LU_MAX) out_d = out_q + OUT_W'(1);
            2'b01:   out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase
    end

    always_comb begin
        if (!IF_ID_stall) wd_d = '0;
        else if (wd_q != WD_MAX) wd_d = wd_q + WD_W'(1);
        else wd_d = wd_q;
        timeout_d = timeout_q || (WD_EN && IF_ID_stall && (wd_d == WD_MAX));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= '0;
            out_q     <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            out_q     <= out_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench for hazard_ctrl_sb: per-cycle expected stall/flush vectors are
// queued when stimulus is driven and popped when the outputs are sampled.
module tb_hazard_ctrl_sb;

    localparam int NR = 32;
    // Vector order: {IF_ID, ID_EX, EX_MEM, MEM_WB stalls, IF_ID, ID_EX, EX_MEM, MEM_WB flushes}
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] BUB    = 8'b1000_0100;
    localparam logic [7:0] ALLST  = 8'b1111_0000;
    localparam logic [7:0] ALLFL  = 8'b0000_1111;
    localparam logic [7:0] REDIR  = 8'b0000_1100;
    localparam logic [7:0] FULLST = 8'b1110_0000;
    localparam logic [7:0] STBY   = 8'b1100_0000;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] ID_rs1, ID_rs2, ID_rd, EX_rd, lu_issue_rd, lu_done_rd;
    logic ID_rs1_valid, ID_rs2_valid, ID_rd_valid, EX_valid, EX_is_load;
    logic lu_issue, lu_done, branch_prediction_miss, EX_jump;
    logic trap_done, csr_ready, standby_mode, pth_done_flush;
    logic IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
    logic IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush;
    logic [NR-1:0] sb_busy;
    logic lu_full, stall_timeout, sb_error;

    int tests = 0;
    int fails = 0;
    logic [7:0] expQ[$];
    logic [7:0] expV;
    wire  [7:0] obs = {IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
                       IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush};

    hazard_ctrl_sb #(
        .REG_ADDR_W(5), .NUM_REGS(NR), .LOAD_USE_CYCLES(2), .LU_DEPTH(2), .WATCHDOG_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_valid(ID_rs1_valid), .ID_rs2_valid(ID_rs2_valid), .ID_rd_valid(ID_rd_valid),
        .EX_valid(EX_valid), .EX_is_load(EX_is_load), .EX_rd(EX_rd),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_done(lu_done), .lu_done_rd(lu_done_rd),
        .branch_prediction_miss(branch_prediction_miss), .EX_jump(EX_jump),
        .trap_done(trap_done), .csr_ready(csr_ready),
        .standby_mode(standby_mode), .pth_done_flush(pth_done_flush),
        .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush),
        .sb_busy(sb_busy), .lu_full(lu_full),
        .stall_timeout(stall_timeout), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

    // Quiet, non-hazard inputs with reset released.
    task automatic idleInputs();
        reset = 1'b1;
        ID_rs1 = '0; ID_rs2 = '0; ID_rd = '0; EX_rd = '0;
        ID_rs1_valid = 0; ID_rs2_valid = 0; ID_rd_valid = 0;
        EX_valid = 0; EX_is_load = 0;
        lu_issue = 0; lu_issue_rd = '0; lu_done = 0; lu_done_rd = '0;
        branch_prediction_miss = 0; EX_jump = 0;
        trap_done = 1; csr_ready = 1; standby_mode = 0; pth_done_flush = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b0;
        trap_done = 1'b0;
        pth_done_flush = 1'b1;
        expQ.push_back(NONE);
        @(negedge clk);
        expV = expQ.pop_front();
        tests++;
        if (obs !== expV) begin
            fails++;
            $display("[TB] FAIL reset_gate: got %b expected %b", obs, expV);
        end
        nextCycle();
        idleInputs();
        expQ.push_back(NONE);
        @(negedge clk);
        expV = expQ.pop_front();
        tests++;
        if (obs !== expV) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", obs, expV);
        end
        tests++;
        if ({sb_busy, lu_full, stall_timeout, sb_error} !== {{NR{1'b0}}, 3'b000}) begin
            fails++;
            $display("[TB] FAIL reset_state: got busy=%h full=%b to=%b err=%b expected all 0",
                     sb_busy, lu_full, stall_timeout, sb_error);
        end
        nextCycle();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 9; i++) begin
            idleInputs();
            case (i)
                0: begin EX_valid = 1; EX_is_load = 1; EX_rd = 5; ID_rs1 = 5; ID_rs1_valid = 1; expQ.push_back(BUB); end
                1: begin ID_rs1 = 5; ID_rs1_valid = 1; expQ.push_back(BUB); end
                2: begin ID_rs1 = 5; ID_rs1_valid = 1; expQ.push_back(NONE); end
                3: begin EX_valid = 1; EX_is_load = 1; EX_rd = 0; ID_rs1 = 0; ID_rs1_valid = 1; expQ.push_back(NONE); end
                4: begin EX_valid = 1; EX_is_load = 0; EX_rd = 6; ID_rs1 = 6; ID_rs1_valid = 1; expQ.push_back(NONE); end
                5: begin EX_valid = 1; EX_is_load = 1; EX_rd = 6; ID_rs1 = 6; ID_rs1_valid = 0; expQ.push_back(NONE); end
                6: begin EX_valid = 1; EX_is_load = 1; EX_rd = 9; ID_rs2 = 9; ID_rs2_valid = 1; expQ.push_back(BUB); end
                7: begin ID_rs2 = 9; ID_rs2_valid = 1; expQ.push_back(BUB); end
                default: expQ.push_back(NONE);
            endcase
            @(negedge clk);
            expV = expQ.pop_front();
            tests++;
            if (obs !== expV) begin
                fails++;
                $display("[TB] FAIL load_use c%0d: got %b expected %b", i, obs, expV);
            end
            nextCycle();
        end
    endtask

    task automatic test_scoreboard();
        for (int i = 0; i < 6; i++) begin
            idleInputs();
            ID_rs2 = 7;
            ID_rs2_valid = (i != 0);
            case (i)
                0: begin lu_issue = 1; lu_issue_rd = 7; expQ.push_back(NONE); end
                3: begin lu_done = 1; lu_done_rd = 7; expQ.push_back(BUB); end
                5: expQ.push_back(NONE);
                default: expQ.push_back(BUB);
            endcase
            @(negedge clk);
            expV = expQ.pop_front();
            tests++;
            if (obs !== expV) begin
                fails++;
                $display("[TB] FAIL scoreboard c%0d: got %b expected %b", i, obs, expV);
            end
            if (i == 1 || i == 4) begin
                tests++;
                if ({sb_busy, lu_full} !== {((i == 1) ? 32'h0000_0080 : 32'h0), 1'b0}) begin
                    fails++;
                    $display("[TB] FAIL sb_busy7 c%0d: got busy=%h full=%b", i, sb_busy, lu_full);
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_lu_full();
        logic [NR-1:0] wantBusy;
        logic          wantFull;
        for (int i = 0; i < 7; i++) begin
            idleInputs();
            wantBusy = 32'h18;
            wantFull = 1'b1;
            case (i)
                0: begin lu_issue = 1; lu_issue_rd = 3; expQ.push_back(NONE); end
                1: begin lu_issue = 1; lu_issue_rd = 4; expQ.push_back(NONE); end
                2: begin lu_issue = 1; lu_issue_rd = 0; expQ.push_back(FULLST); end
                3: begin lu_issue = 1; lu_issue_rd = 3; lu_done = 1; lu_done_rd = 3; expQ.push_back(FULLST); end
                4: begin lu_done = 1; lu_done_rd = 3; expQ.push_back(NONE); end
                5: begin lu_done = 1; lu_done_rd = 4; wantBusy = 32'h10; wantFull = 0; expQ.push_back(NONE); end
                default: begin wantBusy = '0; wantFull = 0; expQ.push_back(NONE); end
            endcase
            @(negedge clk);
            expV = expQ.pop_front();
            tests++;
            if (obs !== expV) begin
                fails++;
                $display("[TB] FAIL lu_full_stall c%0d: got %b expected %b", i, obs, expV);
            end
            if (i >= 2) begin
                tests++;
                if ({sb_busy, lu_full, sb_error} !== {wantBusy, wantFull, 1'b0}) begin
                    fails++;
                    $display("[TB] FAIL lu_full_state c%0d: got busy=%h full=%b err=%b expected busy=%h full=%b err=0",
                             i, sb_busy, lu_full, sb_error, wantBusy, wantFull);
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 12; i++) begin
            idleInputs();
            ID_rs1 = 5;
            ID_rs1_valid = 1;
            case (i)
                0, 4: begin EX_valid = 1; EX_is_load = 1; EX_rd = 5; expQ.push_back(BUB); end
                1: begin trap_done = 0; expQ.push_back(ALLST); end
                2: expQ.push_back(BUB);
                5: begin branch_prediction_miss = 1; expQ.push_back(REDIR); end
                7: begin pth_done_flush = 1; trap_done = 0; expQ.push_back(ALLFL); end
                8: begin standby_mode = 1; expQ.push_back(STBY); end
                9: begin standby_mode = 1; csr_ready = 0; expQ.push_back(ALLST); end
                10: begin EX_jump = 1; expQ.push_back(REDIR); end
                default: expQ.push_back(NONE);
            endcase
            @(negedge clk);
            expV = expQ.pop_front();
            tests++;
            if (obs !== expV) begin
                fails++;
                $display("[TB] FAIL priority c%0d: got %b expected %b", i, obs, expV);
            end
            nextCycle();
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 16; i++) begin
            idleInputs();
            ID_rs1 = 12;
            ID_rs1_valid = (i >= 1 && i <= 12);
            case (i)
                0: begin lu_issue = 1; lu_issue_rd = 12; expQ.push_back(NONE); end
                14: begin lu_done = 1; lu_done_rd = 9; expQ.push_back(NONE); end
                15: expQ.push_back(NONE);
                default: expQ.push_back(BUB);
            endcase
            @(negedge clk);
            expV = expQ.pop_front();
            tests++;
            if (obs !== expV) begin
                fails++;
                $display("[TB] FAIL watchdog_stall c%0d: got %b expected %b", i, obs, expV);
            end
            if (i == 7 || i == 9 || i == 12 || i == 15) begin
                tests++;
                if (stall_timeout !== (i != 7)) begin
                    fails++;
                    $display("[TB] FAIL stall_timeout c%0d: got %b expected %b", i, stall_timeout, (i != 7));
                end
            end
            if (i == 14 || i == 15) begin
                tests++;
                if ({sb_error, sb_busy} !== {(i == 15), 32'h0000_1000}) begin
                    fails++;
                    $display("[TB] FAIL sb_error c%0d: got err=%b busy=%h expected err=%b busy=00001000",
                             i, sb_error, sb_busy, (i == 15));
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            idleInputs();
            ID_rs1 = 12;
            ID_rs1_valid = 1;
            if (i == 2) reset = 1'b0;
            expQ.push_back((i < 2) ? BUB : NONE);
            @(negedge clk);
            expV = expQ.pop_front();
            tests++;
            if (obs !== expV) begin
                fails++;
                $display("[TB] FAIL reset_mid c%0d: got %b expected %b", i, obs, expV);
            end
            if (i == 3) begin
                tests++;
                if ({sb_busy, lu_full, stall_timeout, sb_error} !== {{NR{1'b0}}, 3'b000}) begin
                    fails++;
                    $display("[TB] FAIL reset_mid_state: got busy=%h full=%b to=%b err=%b expected all 0",
                             sb_busy, lu_full, stall_timeout, sb_error);
                end
            end
            nextCycle();
        end
    endtask

    initial begin
        idleInputs();
        reset = 1'b0;
        nextCycle();
        test_reset();
        test_load_use();
        test_scoreboard();
        test_lu_full();
        test_priority();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
